// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C master arbiter: FSM encodings and command layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_e;

  // One latched requester command, exactly what the driver consumes.
  typedef struct packed {
    logic              rh_wl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_w;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among pending requesters, starting the search at ptr_i.
// Latency: purely combinational.
// Backpressure: none; caller decides when to consume the grant.
// Ports: pending_i (request vector), ptr_i (highest-priority index),
//        grant_o (one-hot winner, 0 when nothing pending), winner_o (winner index).
module rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && pending_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one single-byte I2C driver between NUM_REQ exec/done requesters, round-robin.
// Latency: req_exec -> i2c_exec 2 cycles when idle; i2c_done -> req_done 1 cycle.
// Backpressure: one pending command per requester; an exec while pending is dropped (req_overrun).
// Ports: clk/rst_n; req_* per-requester command in and done/ack/data/overrun out;
//        i2c_* driver command out and results in; arb_timeout pulses on watchdog abort.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter logic [15:0] GAP_CYCLES     = 16'd100,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_exec,
  input  logic [NUM_REQ-1:0]        req_rh_wl,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data_w,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_ack,
  output logic [DATA_W-1:0]         req_data_r,
  output logic [NUM_REQ-1:0]        req_overrun,
  output logic                      i2c_exec,
  output logic                      i2c_rh_wl,
  output logic [ADDR_W-1:0]         i2c_addr,
  output logic [DATA_W-1:0]         i2c_data_w,
  input  logic [DATA_W-1:0]         i2c_data_r,
  input  logic                      i2c_done,
  input  logic                      i2c_ack,
  output logic                      arb_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state_q,    state_d;
  logic [NUM_REQ-1:0]   pending_q,  pending_d;
  cmd_t                 cmd_q [NUM_REQ];
  cmd_t                 cmd_d [NUM_REQ];
  logic [NUM_REQ-1:0]   owner_q,    owner_d;     // one-hot owner of the current transaction
  logic [IDX_W-1:0]     rr_ptr_q,   rr_ptr_d;
  logic [15:0]          gap_cnt_q,  gap_cnt_d;
  logic [23:0]          wd_cnt_q,   wd_cnt_d;
  logic                 i2c_exec_q, i2c_exec_d;
  cmd_t                 i2c_cmd_q,  i2c_cmd_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic                 req_ack_q,  req_ack_d;
  logic [DATA_W-1:0]    req_data_r_q, req_data_r_d;
  logic [NUM_REQ-1:0]   overrun_q,  overrun_d;
  logic                 timeout_q,  timeout_d;

  logic [NUM_REQ-1:0]   live;
  logic [NUM_REQ-1:0]   accept;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     winner;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .pending_i (live),
    .ptr_i     (rr_ptr_q),
    .grant_o   (grant),
    .winner_o  (winner)
  );

  always_comb begin
    // A slot whose req_done is on the wire this cycle is already free, so the
    // owner may re-issue in that same cycle without an overrun.
    live      = pending_q & ~req_done_q;
    accept    = req_exec & ~live;
    pending_d = live | accept;
    overrun_d = req_exec & live;
    cmd_d     = cmd_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (accept[k]) begin
        cmd_d[k].rh_wl  = req_rh_wl[k];
        cmd_d[k].addr   = req_addr[ADDR_W*k +: ADDR_W];
        cmd_d[k].data_w = req_data_w[DATA_W*k +: DATA_W];
      end
    end

    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    gap_cnt_d    = gap_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    i2c_exec_d   = 1'b0;
    i2c_cmd_d    = i2c_cmd_q;
    req_done_d   = '0;
    req_ack_d    = req_ack_q;
    req_data_r_d = req_data_r_q;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|live) begin
          state_d    = ST_ISSUE;
          i2c_exec_d = 1'b1;          // registered, so it is high during ISSUE
          owner_d    = grant;
          i2c_cmd_d  = cmd_q[winner];
          rr_ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
      end
      ST_ISSUE: begin
        wd_cnt_d = '0;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i2c_done) begin
          req_done_d   = owner_q;
          req_ack_d    = i2c_ack;
          req_data_r_d = i2c_data_r;
          gap_cnt_d    = '0;
          state_d      = ST_GAP;
        end else if (wd_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
          req_done_d   = owner_q;
          req_ack_d    = 1'b1;
          req_data_r_d = '0;
          timeout_d    = 1'b1;
          gap_cnt_d    = '0;
          state_d      = ST_GAP;
        end else if (wd_cnt_q != '1) begin
          wd_cnt_d = wd_cnt_q + 24'd1;
        end
      end
      ST_GAP: begin
        // The req_done cycle is GAP's first cycle; GAP_CYCLES idle cycles follow
        // it, so the next exec is at earliest done+1+GAP_CYCLES+2.
        if (gap_cnt_q == GAP_CYCLES) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      for (int k = 0; k < NUM_REQ; k++) cmd_q[k] <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      gap_cnt_q    <= '0;
      wd_cnt_q     <= '0;
      i2c_exec_q   <= 1'b0;
      i2c_cmd_q    <= '0;
      req_done_q   <= '0;
      req_ack_q    <= 1'b0;
      req_data_r_q <= '0;
      overrun_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      for (int k = 0; k < NUM_REQ; k++) cmd_q[k] <= cmd_d[k];
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      gap_cnt_q    <= gap_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      i2c_exec_q   <= i2c_exec_d;
      i2c_cmd_q    <= i2c_cmd_d;
      req_done_q   <= req_done_d;
      req_ack_q    <= req_ack_d;
      req_data_r_q <= req_data_r_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_done    = req_done_q;
  assign req_ack     = req_ack_q;
  assign req_data_r  = req_data_r_q;
  assign req_overrun = overrun_q;
  assign i2c_exec    = i2c_exec_q;
  assign i2c_rh_wl   = i2c_cmd_q.rh_wl;
  assign i2c_addr    = i2c_cmd_q.addr;
  assign i2c_data_w  = i2c_cmd_q.data_w;
  assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a hand-driven I2C driver model.
// Latency: checks exec/done/timeout cycle counts against hand-computed values.
// Backpressure: exercises overrun drop and same-cycle re-exec acceptance.
module tb_i2c_master_arbiter;

  localparam logic [15:0] GAP = 16'd4;
  localparam logic [23:0] TMO = 24'd20;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_exec;
  logic [1:0]  req_rh_wl;
  logic [31:0] req_addr;
  logic [15:0] req_data_w;
  logic [1:0]  req_done;
  logic        req_ack;
  logic [7:0]  req_data_r;
  logic [1:0]  req_overrun;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;
  logic        i2c_ack;
  logic        arb_timeout;

  int total = 0;
  int bad   = 0;
  int ovr0  = 0;
  int ovr1  = 0;
  int lat;
  int seen;

  i2c_master_arbiter #(
    .NUM_REQ        (2),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_exec    (req_exec),
    .req_rh_wl   (req_rh_wl),
    .req_addr    (req_addr),
    .req_data_w  (req_data_w),
    .req_done    (req_done),
    .req_ack     (req_ack),
    .req_data_r  (req_data_r),
    .req_overrun (req_overrun),
    .i2c_exec    (i2c_exec),
    .i2c_rh_wl   (i2c_rh_wl),
    .i2c_addr    (i2c_addr),
    .i2c_data_w  (i2c_data_w),
    .i2c_data_r  (i2c_data_r),
    .i2c_done    (i2c_done),
    .i2c_ack     (i2c_ack),
    .arb_timeout (arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr0 <= 0;
      ovr1 <= 0;
    end else begin
      if (req_overrun[0]) ovr0 <= ovr0 + 1;
      if (req_overrun[1]) ovr1 <= ovr1 + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cmd(input int k, input logic rh, input logic [15:0] a, input logic [7:0] d);
    req_rh_wl[k]            = rh;
    req_addr[16*k +: 16]    = a;
    req_data_w[8*k +: 8]    = d;
  endtask

  task automatic fire(input logic [1:0] m);
    req_exec = m;
    tick();
    req_exec = 2'b00;
  endtask

  task automatic wait_exec(output int n);
    n = 0;
    while (i2c_exec !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Wait for the grant, check the command, answer with rd/ack one cycle later,
  // check the completion, optionally re-exec in the req_done cycle.
  task automatic serve(input string tag, input logic rh, input logic [15:0] a, input logic [7:0] d,
                       input logic [1:0] who, input logic [7:0] rd, input logic ack,
                       input logic [1:0] reexec, output int n);
    wait_exec(n);
    chk({tag, ".exec"}, 32'(i2c_exec), 32'(1));
    chk({tag, ".cmd"}, 32'({i2c_rh_wl, i2c_addr, i2c_data_w}), 32'({rh, a, d}));
    tick();
    chk({tag, ".exec_pulse"}, 32'(i2c_exec), 32'(0));
    i2c_done   = 1'b1;
    i2c_data_r = rd;
    i2c_ack    = ack;
    tick();
    i2c_done   = 1'b0;
    i2c_data_r = 8'hEE;
    i2c_ack    = 1'b0;
    chk({tag, ".done"}, 32'(req_done), 32'(who));
    chk({tag, ".result"}, 32'({req_ack, req_data_r}), 32'({ack, rd}));
    req_exec = reexec;
    tick();
    req_exec = 2'b00;
    chk({tag, ".done_pulse"}, 32'(req_done), 32'(0));
  endtask

  initial begin
    rst_n      = 1'b0;
    req_exec   = '0;
    req_rh_wl  = '0;
    req_addr   = '0;
    req_data_w = '0;
    i2c_data_r = '0;
    i2c_done   = 1'b0;
    i2c_ack    = 1'b0;
    idle(3);
    chk("rst.ctl", 32'({i2c_exec, arb_timeout, req_done, req_overrun, req_ack, i2c_rh_wl}), 32'(0));
    chk("rst.dat", 32'({i2c_addr, i2c_data_w, req_data_r}), 32'(0));
    rst_n = 1'b1;
    idle(2);

    // Contention from reset: pointer at 0, so 0 then 1; second grant GAP+1 after the done check.
    set_cmd(0, 1'b0, 16'h0010, 8'h11);
    set_cmd(1, 1'b0, 16'h0020, 8'h22);
    fire(2'b11);
    serve("c1a", 1'b0, 16'h0010, 8'h11, 2'b01, 8'h00, 1'b0, 2'b00, lat);
    chk("c1a.lat", 32'(lat), 32'(1));
    serve("c1b", 1'b0, 16'h0020, 8'h22, 2'b10, 8'h5A, 1'b1, 2'b00, lat);
    chk("c1b.lat", 32'(lat), 32'(5));
    idle(8);

    // Pointer now favors 0 again after the grant to 1.
    set_cmd(0, 1'b0, 16'h0030, 8'h33);
    set_cmd(1, 1'b0, 16'h0040, 8'h44);
    fire(2'b11);
    serve("c2a", 1'b0, 16'h0030, 8'h33, 2'b01, 8'h00, 1'b0, 2'b00, lat);
    serve("c2b", 1'b0, 16'h0040, 8'h44, 2'b10, 8'h00, 1'b0, 2'b00, lat);
    chk("c2b.lat", 32'(lat), 32'(5));
    idle(8);

    // Single write from requester 0.
    set_cmd(0, 1'b0, 16'h0005, 8'hA5);
    fire(2'b01);
    serve("wr", 1'b0, 16'h0005, 8'hA5, 2'b01, 8'h00, 1'b0, 2'b00, lat);
    chk("wr.lat", 32'(lat), 32'(1));
    idle(8);

    // Read by requester 1, which re-issues in the same cycle its done fires.
    set_cmd(1, 1'b1, 16'h00FF, 8'h00);
    fire(2'b10);
    set_cmd(1, 1'b0, 16'h0ABC, 8'h99);
    serve("rd", 1'b1, 16'h00FF, 8'h00, 2'b10, 8'h3C, 1'b0, 2'b10, lat);
    chk("rd.lat", 32'(lat), 32'(1));
    serve("reex", 1'b0, 16'h0ABC, 8'h99, 2'b10, 8'h81, 1'b0, 2'b00, lat);
    chk("reex.lat", 32'(lat), 32'(5));
    chk("reex.no_ovr", 32'(ovr0 + ovr1), 32'(0));
    idle(8);

    // Overrun: second exec while pending is dropped.
    set_cmd(0, 1'b0, 16'h0100, 8'h77);
    fire(2'b01);
    set_cmd(0, 1'b0, 16'h0200, 8'h88);
    fire(2'b01);
    serve("ovr", 1'b0, 16'h0100, 8'h77, 2'b01, 8'h00, 1'b0, 2'b00, lat);
    chk("ovr.lat", 32'(lat), 32'(0));
    chk("ovr.cnt", 32'({ovr1[15:0], ovr0[15:0]}), 32'(1));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i2c_exec === 1'b1) seen++;
    end
    chk("ovr.noreissue", 32'(seen), 32'(0));

    // Watchdog: req 0 hangs, req 1 queued behind it.
    set_cmd(0, 1'b0, 16'h0300, 8'h31);
    set_cmd(1, 1'b0, 16'h0400, 8'h41);
    fire(2'b01);
    fire(2'b10);
    wait_exec(lat);
    chk("wd.cmd", 32'({i2c_rh_wl, i2c_addr, i2c_data_w}), 32'({1'b0, 16'h0300, 8'h31}));
    lat = 0;
    while (arb_timeout !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk("wd.lat", 32'(lat), 32'(21));
    chk("wd.done", 32'(req_done), 32'(2'b01));
    chk("wd.result", 32'({req_ack, req_data_r}), 32'(9'h100));
    tick();
    chk("wd.pulse", 32'(arb_timeout), 32'(0));
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("wd.late_done", 32'(req_done), 32'(0));
    serve("wd2", 1'b0, 16'h0400, 8'h41, 2'b10, 8'hC3, 1'b1, 2'b00, lat);
    chk("wd2.lat", 32'(lat), 32'(4));
    idle(8);

    // Reset in WAIT_DONE with requester 1 still pending.
    set_cmd(0, 1'b1, 16'h0500, 8'h55);
    set_cmd(1, 1'b0, 16'h0600, 8'h66);
    fire(2'b11);
    wait_exec(lat);
    chk("mr.cmd", 32'({i2c_rh_wl, i2c_addr, i2c_data_w}), 32'({1'b1, 16'h0500, 8'h55}));
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr.outs", 32'({req_ack, req_data_r, i2c_exec, i2c_rh_wl, req_done, arb_timeout}), 32'(0));
    chk("mr.cmd_clr", 32'({i2c_addr, i2c_data_w}), 32'(0));
    tick();
    rst_n    = 1'b1;
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("mr.stray", 32'(req_done), 32'(0));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i2c_exec === 1'b1 || req_done !== 2'b00) seen++;
    end
    chk("mr.quiet", 32'(seen), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Shares one single-byte I2C master driver between NUM_REQ independent requesters, such as the EEPROM read/write tester and a second on-board I2C client. Each requester keeps the driver's native exec/done command interface. The arbiter latches each command on its exec pulse, grants the driver round-robin, enforces an idle gap between transactions, and aborts hung transactions with a watchdog. It sits between the requester blocks and the I2C driver.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- GAP_CYCLES, 16'd100: idle clk cycles forced between consecutive driver transactions, ≥1.
- TIMEOUT_CYCLES, 24'd1_000_000: clk cycles allowed from i2c_exec to i2c_done before abort.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_exec  in  NUM_REQ  per-requester command strobe, 1-cycle pulse.
- req_rh_wl  in  NUM_REQ  per-requester read(1)/write(0).
- req_addr  in  16*NUM_REQ  per-requester device-internal address, slice k = [16k+15:16k].
- req_data_w  in  8*NUM_REQ  per-requester write data.
- req_done  out  NUM_REQ  1-cycle completion pulse to the owning requester.
- req_ack  out  1  ack flag (1 = no-ack/error) for the transaction reported by req_done.
- req_data_r  out  8  read data for the transaction reported by req_done.
- req_overrun  out  NUM_REQ  1-cycle pulse when an exec is dropped.
- i2c_exec  out  1  driver start pulse.
- i2c_rh_wl, i2c_addr, i2c_data_w  out  1/16/8  command presented to the driver.
- i2c_data_r, i2c_done, i2c_ack  in  8/1/1  driver results.
- arb_timeout  out  1  1-cycle pulse on watchdog abort.

## Operation
- Per requester: a pending bit and a command register {rh_wl, addr, data_w}. A req_exec pulse with pending=0 sets pending and captures the command. A req_exec pulse with pending=1 is dropped and pulses req_overrun[k]. Pending clears when req_done[k] is emitted.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
  - IDLE: if any pending bit is set, select winner w (round-robin), set owner=w, load i2c_rh_wl/addr/data_w from slot w, go to ISSUE.
  - ISSUE: i2c_exec=1 for exactly this cycle; clear the watchdog; go to WAIT_DONE.
  - WAIT_DONE, on i2c_done: register i2c_data_r and i2c_ack onto req_data_r/req_ack, pulse req_done[owner] next cycle, go to GAP.
  - WAIT_DONE, on watchdog reaching TIMEOUT_CYCLES-1: pulse req_done[owner] with req_ack=1 and req_data_r=8'h00, pulse arb_timeout, go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Round-robin: after a grant to w, priority order is w+1, w+2, … modulo NUM_REQ. After reset, priority starts at requester 0.
- i2c_rh_wl/addr/data_w hold their values from IDLE exit until the next grant.
- i2c_done outside WAIT_DONE is ignored. A late i2c_done after a timeout is ignored.
- The owner's own req_exec in the same cycle its req_done fires is accepted, not an overrun, because pending clears and sets in the same edge.
- Simultaneous exec pulses on several requesters are all captured. They are served in round-robin order.
- rst_n assertion mid-transaction: all state is cleared immediately. The driver receives no further exec. Requesters must re-issue.

## Timing
- Reset values: every output 0; FSM=IDLE; all pending bits 0; rr pointer=0; counters 0.
- req_exec at edge T (FSM idle, no other pending) → pending set at T+1 → FSM in ISSUE at T+2 → i2c_exec high in cycle T+2 (registered).
- i2c_done high in cycle D → req_done and req_data_r/req_ack valid in cycle D+1.
- Next i2c_exec is at earliest D+1+GAP_CYCLES+2.
- The watchdog counts cycles in WAIT_DONE. It saturates and does not wrap.

## Structure
- Shared package i2c_arb_pkg holds the FSM state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT_DONE=2'd2, GAP=2'd3) and the command field widths (ADDR_W=16, DATA_W=8).
- One sub-module, rr_arbiter, is combinational. Inputs: pending vector and rr pointer. Outputs: one-hot grant and winner index.

## Test plan
- Single request: req 0 writes addr 16'h0005, data 8'hA5. i2c_exec appears 2 cycles after req_exec with the correct command, and done returns to req 0 only.
- Simultaneous contention: reqs 0 and 1 exec in the same cycle. Grant order is 0 then 1, separated by ≥GAP_CYCLES idle cycles. Then req 1 and req 0 exec together again: grant order is 0 then 1, because the pointer after the grant to 1 favors 0.
- Read path: req 1 reads addr 16'h00FF and the driver returns 8'h3C with ack=0. req_data_r=8'h3C and req_done[1] pulse one cycle after i2c_done.
- Overrun: req 0 pulses exec twice before done. Exactly one req_overrun[0] pulse, and only the first command is issued.
- Watchdog: the driver never asserts done. After TIMEOUT_CYCLES, arb_timeout and req_done[owner] pulse with req_ack=1, then the next pending request is served.
- Reset mid-WAIT_DONE: all outputs return to 0 and pending bits clear. A stray i2c_done after reset produces no req_done.
